cic_decim_stage: RTL and testbench

- Third-order CIC decimation filter that feeds the transfer FIFO's 16-bit write port.
- Accepts signed ADC samples qualified by in_valid, decimates by DEC_RATIO and emits one 16-bit signed sample per decimation block.
- Runs entirely in the write_clk domain, immediately upstream of the FIFO write controller.

---
 rtl/cic_pkg.sv | 15 +
 rtl/cic_comb_stage.sv | 37 +++
 rtl/cic_decim_stage.sv | 136 +++++++++++++
 tb/tb_cic_decim_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and width helper for the CIC decimator and its golden model.
package cic_pkg;

   localparam int CIC_ORDER     = 3;
   localparam int CIC_DEC_RATIO = 16;
   localparam int CIC_DEC_LOG2  = 4;
   localparam int CIC_IN_W      = 12;
   localparam int CIC_OUT_W     = 16;

   // Accumulator width that holds the full R^N gain without overflow.
   function automatic int cic_acc_w(input int in_w, input int order, input int dec_log2);
      return in_w + order * dec_log2;
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb (differentiator) stage with its stage-valid flag.
module cic_comb_stage
   import cic_pkg::*;
#(
   parameter int W = cic_acc_w(CIC_IN_W, CIC_ORDER, CIC_DEC_LOG2)
) (
   input  logic         write_clk,
   input  logic         reset_bar,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic [W-1:0] out_data,
   output logic         out_valid
);

   logic [W-1:0] diff_reg;
   logic [W-1:0] delay_reg;
   logic         valid_reg;

   // Difference against the previous decimated sample; the flag walks one stage per cycle.
   always_ff @(posedge write_clk) begin
      if (!reset_bar) begin
         diff_reg  <= '0;
         delay_reg <= '0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= in_valid;
         if (in_valid) begin
            diff_reg  <= in_data - delay_reg;
            delay_reg <= in_data;
         end
      end
   end

   assign out_data  = diff_reg;
   assign out_valid = valid_reg;

endmodule

// File: rtl/cic_decim_stage.sv
// CIC decimation filter: inline integrators, decimation counter, comb pipeline, truncating output.
module cic_decim_stage
   import cic_pkg::*;
#(
   parameter int IN_W      = CIC_IN_W,
   parameter int ORDER     = CIC_ORDER,
   parameter int DEC_RATIO = CIC_DEC_RATIO,
   parameter int DEC_LOG2  = CIC_DEC_LOG2,
   parameter int OUT_W     = CIC_OUT_W
) (
   input  logic                    write_clk,
   input  logic                    reset_bar,
   input  logic signed [IN_W-1:0]  data_in,
   input  logic                    in_valid,
   output logic signed [OUT_W-1:0] data_out,
   output logic                    out_valid,
   output logic [7:0]              dec_phase
);

   localparam int         ACC_W      = cic_acc_w(IN_W, ORDER, DEC_LOG2);
   localparam logic [7:0] PHASE_LAST = 8'(DEC_RATIO - 1);

   logic [ACC_W-1:0] data_ext;
   logic [ACC_W-1:0] integ [ORDER];

   logic [7:0]       phase_reg;
   logic [7:0]       phase_next;
   logic             blk_end_reg;
   logic [ACC_W-1:0] c0_reg;
   logic             c0_valid_reg;

   logic [ACC_W-1:0] stage_data [ORDER+1];
   logic [ORDER:0]   stage_valid;

   logic [OUT_W-1:0] data_out_reg;
   logic             out_valid_reg;
   logic             unused_low_bits;

   assign data_ext = {{(ACC_W-IN_W){data_in[IN_W-1]}}, data_in};

   // Integrator chain; modulo-2^ACC_W wrap is harmless because the combs cancel it.
   generate
      for (genvar gi = 0; gi < ORDER; gi++) begin : g_integ
         logic [ACC_W-1:0] acc_reg;
         logic [ACC_W-1:0] addend;

         if (gi == 0) begin : g_src_in
            assign addend = data_ext;
         end else begin : g_src_prev
            assign addend = integ[gi-1];
         end

         // Accumulate on valid beats only, using the previous stage's pre-edge value.
         always_ff @(posedge write_clk) begin
            if (!reset_bar) begin
               acc_reg <= '0;
            end else if (in_valid) begin
               acc_reg <= acc_reg + addend;
            end
         end

         assign integ[gi] = acc_reg;
      end
   endgenerate

   // Next decimation phase: counts valid beats and wraps at the block end.
   always_comb begin
      phase_next = phase_reg;
      if (in_valid) begin
         phase_next = (phase_reg == PHASE_LAST) ? 8'd0 : phase_reg + 8'd1;
      end
   end

   // Phase counter and block-end marker for the beat that closes a block.
   always_ff @(posedge write_clk) begin
      if (!reset_bar) begin
         phase_reg   <= 8'd0;
         blk_end_reg <= 1'b0;
      end else begin
         phase_reg   <= phase_next;
         blk_end_reg <= in_valid && (phase_reg == PHASE_LAST);
      end
   end

   // Capture the last integrator one cycle after the block-end beat.
   always_ff @(posedge write_clk) begin
      if (!reset_bar) begin
         c0_reg       <= '0;
         c0_valid_reg <= 1'b0;
      end else begin
         c0_valid_reg <= blk_end_reg;
         if (blk_end_reg) begin
            c0_reg <= integ[ORDER-1];
         end
      end
   end

   assign stage_data[0]  = c0_reg;
   assign stage_valid[0] = c0_valid_reg;

   generate
      for (genvar gi = 0; gi < ORDER; gi++) begin : g_comb
         cic_comb_stage #(
            .W (ACC_W)
         ) u_comb (
            .write_clk (write_clk),
            .reset_bar (reset_bar),
            .in_data   (stage_data[gi]),
            .in_valid  (stage_valid[gi]),
            .out_data  (stage_data[gi+1]),
            .out_valid (stage_valid[gi+1])
         );
      end
   endgenerate

   // Output register: top OUT_W bits of the last comb, held between strobes.
   always_ff @(posedge write_clk) begin
      if (!reset_bar) begin
         data_out_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= stage_valid[ORDER];
         if (stage_valid[ORDER]) begin
            data_out_reg <= stage_data[ORDER][ACC_W-1 -: OUT_W];
         end
      end
   end

   // Truncated fraction bits are intentionally dropped.
   assign unused_low_bits = ^stage_data[ORDER][ACC_W-OUT_W-1:0];

   assign data_out  = data_out_reg;
   assign out_valid = out_valid_reg;
   assign dec_phase = phase_reg;

endmodule

// File: tb/tb_cic_decim_stage.sv
// Self-checking bench for cic_decim_stage: golden CIC model feeding a strobe scoreboard.
module tb_cic_decim_stage;
   import cic_pkg::*;

   localparam int ACC_W     = cic_acc_w(CIC_IN_W, CIC_ORDER, CIC_DEC_LOG2);
   localparam int ORDER     = CIC_ORDER;
   localparam int DEC_RATIO = CIC_DEC_RATIO;
   localparam int IN_W      = CIC_IN_W;
   localparam int OUT_W     = CIC_OUT_W;

   typedef struct {
      int due;
      int val;
   } sb_entry_t;

   logic                    write_clk = 1'b0;
   logic                    reset_bar;
   logic                    in_valid;
   logic signed [IN_W-1:0]  data_in;
   logic signed [OUT_W-1:0] data_out;
   logic                    out_valid;
   logic [7:0]              dec_phase;

   int checks_cnt = 0;
   int errors_cnt = 0;
   int cyc        = 0;
   int strobe_cnt = 0;
   int last_strobe = -1;
   bit chk_spacing = 1'b0;

   // golden model state
   logic [ACC_W-1:0]        m_int [ORDER];
   logic [ACC_W-1:0]        m_dly [ORDER];
   logic [ACC_W-1:0]        m_y;
   logic [ACC_W-1:0]        m_t;
   logic signed [OUT_W-1:0] m_out;
   int                      m_phase = 0;
   int                      m_last  = 0;
   sb_entry_t               sb [$];
   sb_entry_t               ent;

   cic_decim_stage #(
      .IN_W      (CIC_IN_W),
      .ORDER     (CIC_ORDER),
      .DEC_RATIO (CIC_DEC_RATIO),
      .DEC_LOG2  (CIC_DEC_LOG2),
      .OUT_W     (CIC_OUT_W)
   ) dut (
      .write_clk (write_clk),
      .reset_bar (reset_bar),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .data_out  (data_out),
      .out_valid (out_valid),
      .dec_phase (dec_phase)
   );

   always #5 write_clk = ~write_clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks_cnt++;
      if (obs != exp) begin
         errors_cnt++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Outputs are sampled mid-cycle; inputs seen here are the ones the next edge will take.
   always @(negedge write_clk) begin
      cyc++;
      check("dec_phase", int'(dec_phase), m_phase);
      if (out_valid) begin
         strobe_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            ent = sb.pop_front();
            check("strobe_cycle", cyc, ent.due);
            check("data_out", int'(data_out), ent.val);
            m_last = ent.val;
         end
         if (chk_spacing && last_strobe >= 0)
            check("strobe_spacing", cyc - last_strobe, DEC_RATIO);
         last_strobe = cyc;
         $display("strobe cycle=%0d data_out=%0d", cyc, data_out);
      end else begin
         if (sb.size() != 0 && sb[0].due <= cyc) begin
            check("missing_strobe", 0, 1);
            void'(sb.pop_front());
         end
         check("data_out_hold", int'(data_out), m_last);
      end

      // advance the model by the upcoming edge
      if (!reset_bar) begin
         for (int k = 0; k < ORDER; k++) begin
            m_int[k] = '0;
            m_dly[k] = '0;
         end
         m_phase = 0;
         m_last  = 0;
         last_strobe = -1;
         sb.delete();
      end else if (in_valid) begin
         for (int k = ORDER - 1; k > 0; k--)
            m_int[k] = m_int[k] + m_int[k-1];
         m_int[0] = m_int[0] + {{(ACC_W-IN_W){data_in[IN_W-1]}}, data_in};
         if (m_phase == DEC_RATIO - 1) begin
            m_y = m_int[ORDER-1];
            for (int k = 0; k < ORDER; k++) begin
               m_t      = m_y - m_dly[k];
               m_dly[k] = m_y;
               m_y      = m_t;
            end
            m_out   = m_y[ACC_W-1 -: OUT_W];
            ent.due = cyc + ORDER + 3;
            ent.val = int'(m_out);
            sb.push_back(ent);
            m_phase = 0;
         end else begin
            m_phase++;
         end
      end
   end

   task automatic step();
      @(posedge write_clk);
      #1;
   endtask

   task automatic apply_reset();
      step();
      reset_bar = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      data_in   = IN_W'($urandom_range(0, 4095));
      step();
      reset_bar = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         in_valid = 1'b0;
      end
   endtask

   // Drive n_beats valid beats (random data if rnd) at the given duty, then drain the pipeline.
   task automatic run(input bit rnd, input int dc, input int n_beats, input int duty);
      int beats = 0;
      int guard = 0;
      while (beats < n_beats && guard < n_beats * 20) begin
         step();
         guard++;
         in_valid = ($urandom_range(0, 99) < duty);
         data_in  = rnd ? IN_W'($urandom_range(0, 4095)) : IN_W'(dc);
         if (in_valid) beats++;
      end
      if (beats < n_beats) check("run_timeout", beats, n_beats);
      idle(10);
   endtask

   initial begin
      int base;
      int guard;
      bit found;
      for (int k = 0; k < ORDER; k++) begin
         m_int[k] = '0;
         m_dly[k] = '0;
      end
      reset_bar = 1'b0;
      in_valid  = 1'b0;
      data_in   = '0;
      step();
      step();

      // Test 1: continuous DC +100
      apply_reset();
      step();
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_data_out", int'(data_out), 0);
      check("reset_dec_phase", int'(dec_phase), 0);
      base = strobe_cnt;
      chk_spacing = 1'b1;
      run(1'b0, 100, 16 * 6, 100);
      chk_spacing = 1'b0;
      check("t1_strobe_count", strobe_cnt - base, 6);
      check("t1_dc100", int'(data_out), 1600);

      // Test 2: full-scale DC both polarities
      apply_reset();
      run(1'b0, 2047, 16 * 190, 100);
      check("t2_pos_fullscale", int'(data_out), 32752);
      apply_reset();
      run(1'b0, -2048, 16 * 6, 100);
      check("t2_neg_fullscale", int'(data_out), -32768);

      // Test 3: gapped valid, DC +100
      apply_reset();
      run(1'b0, 100, 16 * 8, 40);
      check("t3_gapped_dc100", int'(data_out), 1600);

      // Test 4: random data, random valid
      apply_reset();
      base = strobe_cnt;
      run(1'b1, 0, 16 * 600, 60);
      check("t4_strobe_count", strobe_cnt - base, 600);

      // Test 5: reset mid-block at dec_phase 9
      apply_reset();
      guard = 0;
      found = 1'b0;
      while (!found && guard < 200) begin
         step();
         guard++;
         if (guard > 20 && dec_phase == 8'd9) begin
            found = 1'b1;
            reset_bar = 1'b0;
         end else begin
            in_valid = 1'b1;
            data_in  = 12'sd100;
         end
      end
      check("t5_found_phase9", int'(found), 1);
      step();
      check("t5_out_valid", int'(out_valid), 0);
      check("t5_data_out", int'(data_out), 0);
      check("t5_dec_phase", int'(dec_phase), 0);
      reset_bar = 1'b1;
      in_valid  = 1'b1;
      data_in   = 12'sd100;
      base  = strobe_cnt;
      guard = 0;
      while (strobe_cnt < base + 4 && guard < 200) begin
         step();
         guard++;
      end
      check("t5_strobes_after_reset", strobe_cnt - base, 4);
      check("t5_resettled", int'(data_out), 1600);
      idle(10);

      // Test 6: reset while the comb pipeline is in flight (block end + 3)
      apply_reset();
      guard = 0;
      found = 1'b0;
      while (!found && guard < 200) begin
         step();
         guard++;
         in_valid = 1'b1;
         data_in  = 12'sd100;
         if (guard > 20 && dec_phase == 8'(DEC_RATIO - 1)) found = 1'b1;
      end
      check("t6_found_block_end", int'(found), 1);
      step();
      step();
      step();
      reset_bar = 1'b0;
      base = strobe_cnt;
      step();
      reset_bar = 1'b1;
      in_valid  = 1'b0;
      idle(12);
      check("t6_no_inflight_strobe", strobe_cnt - base, 0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
